// File: rtl/clkrst_pkg.sv
// Shared types for the clock/reset divider generator: lock FSM states,
// the per-channel shadow configuration record and its clamp helper.
package clkrst_pkg;

  // Config fields are sized for the widest supported divide width; narrower
  // configurations zero-extend into them, so the upper bits stay constant.
  localparam int DIV_W_MAX = 16;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_LOCKING,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic [DIV_W_MAX-1:0] phase;
    logic                 en;
  } chan_cfg_t;

  // Turns a raw programmed config into the effective one: period of at least
  // 2, and a phase that falls back to 0 when it does not fit in the period.
  function automatic chan_cfg_t clampCfg(input chan_cfg_t raw);
    chan_cfg_t eff;
    eff = raw;
    if (raw.div < DIV_W_MAX'(2)) begin
      eff.div = DIV_W_MAX'(2);
    end
    if (raw.phase >= eff.div) begin
      eff.phase = '0;
    end
    return eff;
  endfunction

endpackage

// File: rtl/clkrst_divchan.sv
// One divided-clock channel: a phase counter that realigns whenever the
// generator enters LOCKED, producing a registered clock level and a
// one-cycle enable pulse at each rising edge of that clock.
module clkrst_divchan #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             outclk_o,
  output logic             clk_en_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   highCnt;
  logic             active;
  logic             outclk_q, outclk_d;
  logic             clkEn_q, clkEn_d;

  // Next counter value: preload (P - ph) mod P on lock entry, wrap mod P
  // while locked, park at zero otherwise; outputs decode the next count.
  always_comb begin
    highCnt = ({1'b0, period_i} + (CNT_W+1)'(1)) >> 1;
    cnt_d   = '0;
    if (load_i) begin
      cnt_d = (phase_i == '0) ? '0 : period_i - phase_i;
    end else if (run_i) begin
      cnt_d = (cnt_q == period_i - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
    end
    active   = (load_i || run_i) && en_i;
    outclk_d = active && ({1'b0, cnt_d} < highCnt);
    clkEn_d  = active && (cnt_d == '0);
  end

  // Counter and glitch-free registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      clkEn_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      clkEn_q  <= clkEn_d;
    end
  end

  assign outclk_o = outclk_q;
  assign clk_en_o = clkEn_q;

endmodule

// File: rtl/clkrst_divgen.sv
// Clock/reset generator: lock sequencer, per-channel config shadow with a
// valid/ready programming port, staggered domain reset release and one
// divider channel per output clock.
module clkrst_divgen
  import clkrst_pkg::*;
#(
  parameter int                  NUM_CLOCKS  = 3,
  parameter int                  DIV_W       = 8,
  parameter int                  LOCK_CYCLES = 16,
  parameter int                  RST_STAGGER = 4,
  parameter int                  DEF_DIV     = 4,
  parameter logic [NUM_CLOCKS-1:0] DEF_EN    = '1,
  localparam int                 CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [CHAN_W-1:0]     cfg_chan_i,
  input  logic [DIV_W-1:0]      cfg_div_i,
  input  logic [DIV_W-1:0]      cfg_phase_i,
  input  logic                  cfg_en_i,
  output logic [NUM_CLOCKS-1:0] outclk_o,
  output logic [NUM_CLOCKS-1:0] clk_en_o,
  output logic [NUM_CLOCKS-1:0] rst_out_o,
  output logic                  locked_o
);

  localparam int                LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam int                STG_MAX   = RST_STAGGER * NUM_CLOCKS;
  localparam int                STG_W     = $clog2(STG_MAX + 1);
  localparam logic [STG_W-1:0]  STG_TOP   = STG_W'(STG_MAX);
  localparam logic [STG_W-1:0]  STG_STEP  = STG_W'(RST_STAGGER);
  localparam logic [CHAN_W:0]   NUM_CH    = (CHAN_W+1)'(NUM_CLOCKS);

  state_t                  state_q, state_d;
  logic [LOCK_W-1:0]       lockCnt_q, lockCnt_d;
  logic [STG_W-1:0]        stagCnt_q, stagCnt_d;
  logic [NUM_CLOCKS-1:0]   rstOut_q, rstOut_d;
  chan_cfg_t               shadow_q [NUM_CLOCKS];
  chan_cfg_t               effCfg   [NUM_CLOCKS];
  logic [STG_W-1:0]        releaseAt [NUM_CLOCKS];
  logic [STG_W-1:0]        nextRelease;
  logic                    chanValid;
  logic                    cfgWrite;
  logic                    enterLock;
  logic                    stayLock;

  assign chanValid   = ({1'b0, cfg_chan_i} < NUM_CH);
  assign cfg_ready_o = (state_q == ST_LOCKED);
  assign locked_o    = (state_q == ST_LOCKED);
  assign enterLock   = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
  assign stayLock    = (state_d == ST_LOCKED) && (state_q == ST_LOCKED);

  // Lock sequencer: the reset state doubles as LOCKING cycle 0, and an
  // accepted write to a real channel restarts locking from cycle 0.
  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    cfgWrite  = 1'b0;
    case (state_q)
      ST_RESET, ST_LOCKING: begin
        if (lockCnt_q == LOCK_LAST) begin
          state_d   = ST_LOCKED;
          lockCnt_d = '0;
        end else begin
          state_d   = ST_LOCKING;
          lockCnt_d = lockCnt_q + LOCK_W'(1);
        end
      end
      ST_LOCKED: begin
        if (cfg_valid_i && chanValid) begin
          cfgWrite  = 1'b1;
          state_d   = ST_LOCKING;
          lockCnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_RESET;
        lockCnt_d = '0;
      end
    endcase
  end

  // Effective per-channel config after clamping the programmed values.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      effCfg[i] = clampCfg(shadow_q[i]);
    end
  end

  // Reset release: a saturating count of locked cycles compared against
  // thresholds that step by RST_STAGGER for each enabled channel in order.
  always_comb begin
    stagCnt_d = '0;
    if (stayLock) begin
      stagCnt_d = (stagCnt_q == STG_TOP) ? stagCnt_q : stagCnt_q + STG_W'(1);
    end
    nextRelease = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (shadow_q[i].en) begin
        nextRelease = nextRelease + STG_STEP;
      end
      releaseAt[i] = nextRelease;
      rstOut_d[i]  = !((enterLock || stayLock) && shadow_q[i].en &&
                       (stagCnt_d >= releaseAt[i]));
    end
  end

  // Sequencer, stagger counter and registered domain resets.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q   <= ST_RESET;
      lockCnt_q <= '0;
      stagCnt_q <= '0;
      rstOut_q  <= '1;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
      stagCnt_q <= stagCnt_d;
      rstOut_q  <= rstOut_d;
    end
  end

  // Config shadow: defaults on reset, one channel rewritten per transfer.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        shadow_q[i] <= '{div: DIV_W_MAX'(DEF_DIV), phase: '0, en: DEF_EN[i]};
      end
    end else if (cfgWrite) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_chan_i == CHAN_W'(i)) begin
          shadow_q[i] <= '{div:   DIV_W_MAX'(cfg_div_i),
                           phase: DIV_W_MAX'(cfg_phase_i),
                           en:    cfg_en_i};
        end
      end
    end
  end

  assign rst_out_o = rstOut_q;

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : gChan
    clkrst_divchan #(
      .CNT_W (DIV_W_MAX)
    ) uChan (
      .clk_i    (refclk_i),
      .rst_i    (rst_i),
      .load_i   (enterLock),
      .run_i    (stayLock),
      .en_i     (effCfg[g].en),
      .period_i (effCfg[g].div),
      .phase_i  (effCfg[g].phase),
      .outclk_o (outclk_o[g]),
      .clk_en_o (clk_en_o[g])
    );
  end

endmodule

// File: tb/tb_clkrst_divgen.sv
// Bench for clkrst_divgen: a cycle-indexed arithmetic model predicts every
// output each cycle, and a few literal expectations pin that model.
module tb_clkrst_divgen;

  localparam int NC     = 3;
  localparam int LOCK   = 16;
  localparam int STAG   = 4;
  localparam int DEFDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfgValid = 1'b0;
  logic       cfgReady;
  logic [1:0] cfgChan = '0;
  logic [7:0] cfgDiv = '0;
  logic [7:0] cfgPhase = '0;
  logic       cfgEn = 1'b0;
  logic [2:0] outclk, clkEn, rstOut;
  logic       locked;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: cycle index, first locked cycle of the current epoch and
  // the programmed config of each channel.
  int cyc = 0;
  int lockAt = 0;
  bit modelOn = 1'b0;
  int mDiv [NC];
  int mPh  [NC];
  bit mEn  [NC];

  always #5 clk = ~clk;

  clkrst_divgen #(
    .NUM_CLOCKS  (NC),
    .DIV_W       (8),
    .LOCK_CYCLES (LOCK),
    .RST_STAGGER (STAG),
    .DEF_DIV     (DEFDIV),
    .DEF_EN      (3'b111)
  ) dut (
    .refclk_i    (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReady),
    .cfg_chan_i  (cfgChan),
    .cfg_div_i   (cfgDiv),
    .cfg_phase_i (cfgPhase),
    .cfg_en_i    (cfgEn),
    .outclk_o    (outclk),
    .clk_en_o    (clkEn),
    .rst_out_o   (rstOut),
    .locked_o    (locked)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected outputs for cycle t straight from the divider/stagger rules.
  function automatic void computeExpected(input int t, output logic lk,
                                          output logic [2:0] eo,
                                          output logic [2:0] ec,
                                          output logic [2:0] er);
    int n, p, ph, c, thr;
    lk  = (t >= lockAt);
    n   = t - lockAt;
    thr = 0;
    eo  = '0;
    ec  = '0;
    er  = '1;
    for (int i = 0; i < NC; i++) begin
      p  = (mDiv[i] < 2) ? 2 : mDiv[i];
      ph = (mPh[i] < p) ? mPh[i] : 0;
      if (mEn[i]) thr = thr + STAG;
      if (lk && mEn[i]) begin
        c     = ((p - ph) % p + n) % p;
        eo[i] = (c < (p + 1) / 2);
        ec[i] = (c == 0);
        er[i] = !(n >= thr);
      end
    end
  endfunction

  // Model update on each rising edge, seeing the same inputs as the DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      modelOn <= 1'b1;
      lockAt  <= cyc + 1 + LOCK;
      for (int i = 0; i < NC; i++) begin
        mDiv[i] <= DEFDIV;
        mPh[i]  <= 0;
        mEn[i]  <= 1'b1;
      end
    end else if (modelOn && cfgValid && (cyc >= lockAt)) begin
      if (int'(cfgChan) < NC) begin
        mDiv[cfgChan] <= int'(cfgDiv);
        mPh[cfgChan]  <= int'(cfgPhase);
        mEn[cfgChan]  <= cfgEn;
        lockAt        <= cyc + 1 + LOCK;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic       lk;
    logic [2:0] eo, ec, er;
    if (modelOn) begin
      computeExpected(cyc, lk, eo, ec, er);
      checkOutput($sformatf("cyc%0d locked", cyc), locked, lk);
      checkOutput($sformatf("cyc%0d cfg_ready", cyc), cfgReady, lk);
      checkOutput($sformatf("cyc%0d outclk", cyc), outclk, eo);
      checkOutput($sformatf("cyc%0d clk_en", cyc), clkEn, ec);
      checkOutput($sformatf("cyc%0d rst_out", cyc), rstOut, er);
    end
  end

  task automatic gotoCycle(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  // Programs one channel and returns just after the transfer edge.
  task automatic applyStimulus(input int chan, input int div, input int ph,
                               input bit en);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    cfgChan  = 2'(chan);
    cfgDiv   = 8'(div);
    cfgPhase = 8'(ph);
    cfgEn    = en;
    cfgValid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (cfgReady === 1'b1) done = 1'b1;
    end
    checkOutput("handshake completes", done, 1'b1);
    if (done) begin
      @(posedge clk);
      #1;
    end
    cfgValid = 1'b0;
  endtask

  initial begin
    int t0, tT, tR, w;

    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, tT, tR, w;

    // Power-up
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
    gotoCycle(t0);
    checkOutput("pin reset rst_out", rstOut, 3'b111);
    gotoCycle(t0 + 15);
    checkOutput("pin locked before 16", locked, 1'b0);
    gotoCycle(t0 + 16);
    checkOutput("pin locked at 16", locked, 1'b1);
    checkOutput("pin outclk at 16", outclk, 3'b111);
    checkOutput("pin clk_en at 16", clkEn, 3'b111);
    gotoCycle(t0 + 17);
    checkOutput("pin outclk at 17", outclk, 3'b111);
    checkOutput("pin clk_en at 17", clkEn, 3'b000);
    gotoCycle(t0 + 18);
    checkOutput("pin outclk at 18", outclk, 3'b000);
    gotoCycle(t0 + 19);
    checkOutput("pin rst_out at 19", rstOut, 3'b111);
    gotoCycle(t0 + 20);
    checkOutput("pin clk_en at 20", clkEn, 3'b111);
    checkOutput("pin rst_out at 20", rstOut, 3'b110);
    gotoCycle(t0 + 24);
    checkOutput("pin rst_out at 24", rstOut, 3'b100);
    gotoCycle(t0 + 28);
    checkOutput("pin rst_out at 28", rstOut, 3'b000);

    // Reprogram channel 1: period 5, phase 2
    applyStimulus(1, 5, 2, 1'b1);
    tT = cyc;
    gotoCycle(tT);
    checkOutput("pin relock drops locked", locked, 1'b0);
    checkOutput("pin relock rst_out", rstOut, 3'b111);
    gotoCycle(tT + 16);
    checkOutput("pin ch1 locked again", locked, 1'b1);
    checkOutput("pin ch1 clk_en at lock", clkEn[1], 1'b0);
    checkOutput("pin ch1 outclk at lock", outclk[1], 1'b0);
    gotoCycle(tT + 18);
    checkOutput("pin ch1 clk_en at lock+2", clkEn[1], 1'b1);
    checkOutput("pin ch1 outclk at lock+2", outclk[1], 1'b1);
    gotoCycle(tT + 20);
    checkOutput("pin ch1 outclk at lock+4", outclk[1], 1'b1);
    gotoCycle(tT + 21);
    checkOutput("pin ch1 outclk at lock+5", outclk[1], 1'b0);

    // Clamping on channel 2: div 1 / phase 7, then div 0
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2, (k == 0) ? 1 : 0, (k == 0) ? 7 : 0, 1'b1);
      tT = cyc;
      gotoCycle(tT + 16);
      checkOutput("pin ch2 clamp outclk lock", outclk[2], 1'b1);
      gotoCycle(tT + 17);
      checkOutput("pin ch2 clamp outclk lock+1", outclk[2], 1'b0);
      gotoCycle(tT + 18);
      checkOutput("pin ch2 clamp clk_en lock+2", clkEn[2], 1'b1);
    end

    // Disable channel 1
    applyStimulus(1, 5, 2, 1'b0);
    tT = cyc;
    gotoCycle(tT + 19);
    checkOutput("pin disabled rst_out lock+3", rstOut, 3'b111);
    gotoCycle(tT + 20);
    checkOutput("pin disabled rst_out lock+4", rstOut, 3'b110);
    checkOutput("pin disabled outclk1", outclk[1], 1'b0);
    gotoCycle(tT + 24);
    checkOutput("pin disabled rst_out lock+8", rstOut, 3'b010);

    // Invalid channel is accepted and discarded
    applyStimulus(3, 9, 9, 1'b1);
    tT = cyc;
    gotoCycle(tT);
    checkOutput("pin invalid chan keeps lock", locked, 1'b1);
    gotoCycle(tT + 3);
    checkOutput("pin invalid chan lock later", locked, 1'b1);

    // Randomised reprogramming, including channel 3 and odd periods
    for (int r = 0; r < 25; r++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 14)), ($urandom_range(0, 3) != 0));
      w = int'($urandom_range(16, 40));
      gotoCycle(cyc + w);
    end

    // Reset during LOCKING cycle 7 after a reprogram
    applyStimulus(0, 7, 3, 1'b1);
    tT = cyc;
    gotoCycle(tT + 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tR = cyc;
    gotoCycle(tR);
    checkOutput("pin mid-lock reset locked", locked, 1'b0);
    checkOutput("pin mid-lock reset rst_out", rstOut, 3'b111);
    gotoCycle(tR + 16);
    checkOutput("pin defaults locked", locked, 1'b1);
    checkOutput("pin defaults outclk", outclk, 3'b111);
    checkOutput("pin defaults clk_en", clkEn, 3'b111);
    gotoCycle(tR + 18);
    checkOutput("pin defaults outclk low", outclk, 3'b000);
    gotoCycle(tR + 40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
